// File: rtl/latency_driver.sv
// latency_driver: drives LFSR operands into the DUT and measures its pipeline
// latency by injecting marker operands, repeating the measurement N_RUNS times.
module latency_driver #(
    parameter int WIDTH = 32,
    parameter int MON_DELAY = 2,
    parameter int SETTLE = 16,
    parameter int MAX_LAT = 255,
    parameter int LAT_W = 8,
    parameter int N_RUNS = 4,
    parameter logic [WIDTH-1:0] MARKER_A = '0,
    parameter logic [WIDTH-1:0] MARKER_B = '0,
    parameter logic [WIDTH-1:0] MARKER_OUT = '0
) (
    input  logic             clk_dut,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_rand_a,
    input  logic [WIDTH-1:0] i_rand_b,
    input  logic [WIDTH-1:0] i_dut_out,
    output logic [WIDTH-1:0] o_drive_a,
    output logic [WIDTH-1:0] o_drive_b,
    output logic [WIDTH-1:0] o_drive_delayed_a,
    output logic [WIDTH-1:0] o_drive_delayed_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [LAT_W-1:0] o_latency,
    output logic             o_timeout,
    output logic             o_mismatch,
    output logic [3:0]       o_run_count
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);
    localparam logic [3:0] N_LAST = 4'(N_RUNS - 1);

    generate
        if (MAX_LAT >= (2 ** LAT_W) || MAX_LAT < 1) begin : g_bad_lat
            $error("MAX_LAT does not fit in LAT_W bits");
        end
        if (N_RUNS < 1 || N_RUNS > 15) begin : g_bad_runs
            $error("N_RUNS out of range 1..15");
        end
        if (MON_DELAY < 0 || MON_DELAY > 15) begin : g_bad_dly
            $error("MON_DELAY out of range 0..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_INJECT,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [SET_W-1:0] settle_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             mark;
    logic             run_done;
    logic             run_to;
    logic [LAT_W-1:0] run_lat;
    logic             clr_res;

    assign mark = (i_dut_out == MARKER_OUT);
    assign clr_res = (state == S_IDLE) || (state == S_DONE && i_start);

    assign o_drive_a = (state == S_INJECT) ? MARKER_A : i_rand_a;
    assign o_drive_b = (state == S_INJECT) ? MARKER_B : i_rand_b;
    assign o_busy = (state == S_SETTLE) || (state == S_INJECT) ||
                    (state == S_MEASURE);
    assign o_done = (state == S_DONE);

    always_comb begin
        state_n = state;
        run_done = 1'b0;
        run_to = 1'b0;
        run_lat = '0;
        unique case (state)
            S_IDLE: begin
                if (i_start) state_n = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == SET_LAST && !mark) state_n = S_INJECT;
            end
            S_INJECT: begin
                if (mark) run_done = 1'b1;
                else state_n = S_MEASURE;
            end
            S_MEASURE: begin
                if (mark) begin
                    run_done = 1'b1;
                    run_lat = lat_cnt;
                end else if (lat_cnt == MAX_L) begin
                    run_done = 1'b1;
                    run_to = 1'b1;
                    run_lat = MAX_L;
                end
            end
            S_DONE: begin
                if (i_start) state_n = S_SETTLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (run_done) state_n = (o_run_count == N_LAST) ? S_DONE : S_SETTLE;
    end

    always_ff @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            settle_cnt <= '0;
            lat_cnt <= '0;
            o_latency <= '0;
            o_timeout <= 1'b0;
            o_mismatch <= 1'b0;
            o_run_count <= '0;
        end else begin
            state <= state_n;
            if (clr_res) begin
                settle_cnt <= '0;
                o_run_count <= '0;
                o_timeout <= 1'b0;
                o_mismatch <= 1'b0;
            end
            // settle counter holds at its exit value while the marker persists
            if (state == S_SETTLE && settle_cnt != SET_LAST)
                settle_cnt <= settle_cnt + SET_W'(1);
            if (state == S_INJECT) lat_cnt <= LAT_W'(1);
            if (state == S_MEASURE && !run_done)
                lat_cnt <= lat_cnt + LAT_W'(1);
            if (run_done) begin
                if (o_run_count == 4'd0) o_latency <= run_lat;
                else if (run_lat != o_latency) o_mismatch <= 1'b1;
                if (run_to) o_timeout <= 1'b1;
                o_run_count <= o_run_count + 4'd1;
                settle_cnt <= '0;
            end
        end
    end

    generate
        if (MON_DELAY == 0) begin : g_nodly
            assign o_drive_delayed_a = i_rand_a;
            assign o_drive_delayed_b = i_rand_b;
        end else begin : g_dly
            logic [WIDTH-1:0] dly_a [MON_DELAY];
            logic [WIDTH-1:0] dly_b [MON_DELAY];
            always_ff @(posedge clk_dut) begin
                dly_a[0] <= i_rand_a;
                dly_b[0] <= i_rand_b;
                for (int i = 1; i < MON_DELAY; i++) begin
                    dly_a[i] <= dly_a[i-1];
                    dly_b[i] <= dly_b[i-1];
                end
            end
            assign o_drive_delayed_a = dly_a[MON_DELAY-1];
            assign o_drive_delayed_b = dly_b[MON_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_latency_driver.sv
// tb_latency_driver: random-operand bench with a run-timeline reference model
// and a programmable-latency adder standing in for the DUT.
module tb_latency_driver;
    localparam int W = 32;
    localparam int SET = 16;
    localparam int MAXL = 255;
    localparam int NR = 4;
    localparam int STUCK = 1000;

    logic clk_dut = 1'b0;
    logic reset_n = 1'b0;
    logic i_start = 1'b0;
    logic [W-1:0] ra = '0;
    logic [W-1:0] rb = '0;
    logic [W-1:0] dut_out;

    logic [W-1:0] m_da, m_db, m_dda, m_ddb;
    logic m_busy, m_done, m_to, m_mm;
    logic [7:0] m_lat;
    logic [3:0] m_rc;
    logic [W-1:0] z_da, z_db, z_dda, z_ddb;
    logic z_busy, z_done, z_to, z_mm;
    logic [7:0] z_lat;
    logic [3:0] z_rc;

    int checks = 0;
    int errors = 0;
    int plan [NR];
    int mplan [NR];
    logic [W-1:0] pipe [1:255];
    bit act = 1'b0;
    bit fin = 1'b0;
    int k = 0;
    logic [W-1:0] ha [3];
    logic [W-1:0] hb [3];
    int nrand = 0;
    int run_idx;
    int cur;

    always #5 clk_dut = ~clk_dut;

    latency_driver #(.MON_DELAY(2)) u_m (
        .clk_dut(clk_dut), .reset_n(reset_n), .i_start(i_start),
        .i_rand_a(ra), .i_rand_b(rb), .i_dut_out(dut_out),
        .o_drive_a(m_da), .o_drive_b(m_db),
        .o_drive_delayed_a(m_dda), .o_drive_delayed_b(m_ddb),
        .o_busy(m_busy), .o_done(m_done), .o_latency(m_lat),
        .o_timeout(m_to), .o_mismatch(m_mm), .o_run_count(m_rc)
    );

    latency_driver #(.MON_DELAY(0)) u_z (
        .clk_dut(clk_dut), .reset_n(reset_n), .i_start(i_start),
        .i_rand_a(ra), .i_rand_b(rb), .i_dut_out(dut_out),
        .o_drive_a(z_da), .o_drive_b(z_db),
        .o_drive_delayed_a(z_dda), .o_drive_delayed_b(z_ddb),
        .o_busy(z_busy), .o_done(z_done), .o_latency(z_lat),
        .o_timeout(z_to), .o_mismatch(z_mm), .o_run_count(z_rc)
    );

    function automatic int eff(int r);
        return (mplan[r] > MAXL) ? MAXL : mplan[r];
    endfunction

    function automatic int end_of(int r);
        int s = 0;
        for (int i = 0; i <= r; i++) s += SET + 1 + eff(i);
        return s;
    endfunction

    function automatic int runs_done(int kk);
        int n = 0;
        for (int r = 0; r < NR; r++) if (end_of(r) < kk) n++;
        return n;
    endfunction

    function automatic bit is_inj(int kk);
        bit hit = 1'b0;
        for (int r = 0; r < NR; r++)
            if (((r == 0) ? 0 : end_of(r - 1)) + SET + 1 == kk) hit = 1'b1;
        return hit;
    endfunction

    // timeline model: k counts busy cycles since the accepted start
    always @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) begin
            act <= 1'b0;
            fin <= 1'b0;
            k <= 0;
        end else if (act) begin
            if (k == end_of(NR - 1)) begin
                act <= 1'b0;
                fin <= 1'b1;
            end
            k <= k + 1;
        end else if (i_start) begin
            act <= 1'b1;
            fin <= 1'b0;
            k <= 1;
            mplan <= plan;
        end
    end

    always @(posedge clk_dut) begin
        pipe[1] <= m_da + m_db;
        for (int i = 2; i <= 255; i++) pipe[i] <= pipe[i-1];
    end

    always_comb begin
        run_idx = act ? runs_done(k) : NR - 1;
        if (run_idx > NR - 1) run_idx = NR - 1;
        cur = mplan[run_idx];
        if (cur > MAXL) dut_out = 32'h1;
        else if (cur == 0) dut_out = m_da + m_db;
        else dut_out = pipe[cur];
    end

    initial begin
        forever begin
            @(posedge clk_dut);
            #1;
            ha[2] = ha[1];
            ha[1] = ha[0];
            hb[2] = hb[1];
            hb[1] = hb[0];
            ra = $urandom;
            rb = $urandom;
            ha[0] = ra;
            hb[0] = rb;
            nrand++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic cmp_inst(input string p,
                            input logic [W-1:0] da, input logic [W-1:0] db,
                            input logic [W-1:0] dda, input logic [W-1:0] ddb,
                            input logic busy, input logic done,
                            input logic [7:0] lat, input logic to,
                            input logic mm, input logic [3:0] rc,
                            input int dly);
        int rcn;
        bit e_to;
        bit e_mm;
        bit inj;
        inj = act && is_inj(k);
        chk({p, ".drive_a"}, da, inj ? '0 : ra);
        chk({p, ".drive_b"}, db, inj ? '0 : rb);
        chk({p, ".dly_a"}, dda, (dly == 0) ? ra : ha[2]);
        chk({p, ".dly_b"}, ddb, (dly == 0) ? rb : hb[2]);
        chk({p, ".busy"}, busy, act);
        chk({p, ".done"}, done, fin);
        if (!act && !fin) rcn = 0;
        else if (fin) rcn = NR;
        else rcn = runs_done(k);
        e_to = 1'b0;
        e_mm = 1'b0;
        for (int r = 0; r < rcn; r++) begin
            if (mplan[r] > MAXL) e_to = 1'b1;
            if (r > 0 && eff(r) != eff(0)) e_mm = 1'b1;
        end
        chk({p, ".run_count"}, rc, rcn);
        chk({p, ".timeout"}, to, e_to);
        chk({p, ".mismatch"}, mm, e_mm);
        if (!act && !fin) chk({p, ".latency"}, lat, 0);
        else if (rcn >= 1) chk({p, ".latency"}, lat, eff(0));
    endtask

    always @(negedge clk_dut) begin
        if (nrand >= 3) begin
            cmp_inst("m", m_da, m_db, m_dda, m_ddb, m_busy, m_done,
                     m_lat, m_to, m_mm, m_rc, 2);
            cmp_inst("z", z_da, z_db, z_dda, z_ddb, z_busy, z_done,
                     z_lat, z_to, z_mm, z_rc, 0);
        end
    end

    task automatic set_plan(input int p0, input int p1,
                            input int p2, input int p3);
        plan[0] = p0;
        plan[1] = p1;
        plan[2] = p2;
        plan[3] = p3;
    endtask

    task automatic pulse_start();
        @(posedge clk_dut);
        #1 i_start = 1'b1;
        @(posedge clk_dut);
        #1 i_start = 1'b0;
    endtask

    // n returns the number of busy cycles before o_done rose
    task automatic run_seq(input bit extra, output int n);
        bit seen = 1'b0;
        repeat (300) @(posedge clk_dut);
        pulse_start();
        n = 0;
        while (!seen && n < 3000) begin
            @(negedge clk_dut);
            n++;
            if (extra && n == 5) i_start = 1'b1;
            if (extra && n == 6) i_start = 1'b0;
            if (m_done) seen = 1'b1;
        end
        chk("seq_reaches_done", seen, 1'b1);
        n = n - 1;
    endtask

    initial begin
        int n;
        int base;
        set_plan(0, 0, 0, 0);
        repeat (3) @(posedge clk_dut);
        @(negedge clk_dut);
        chk("reset_busy", m_busy, 1'b0);
        chk("reset_latency", m_lat, 0);
        reset_n = 1'b1;

        set_plan(3, 3, 3, 3);
        run_seq(1'b0, n);
        chk("lat3_cycles", n, 80);
        chk("lat3_latency", m_lat, 3);
        chk("lat3_runs", m_rc, 4);
        chk("lat3_mismatch", m_mm, 1'b0);
        chk("lat3_timeout", m_to, 1'b0);

        set_plan(0, 0, 0, 0);
        run_seq(1'b0, n);
        chk("comb_cycles", n, 68);
        chk("comb_latency", m_lat, 0);

        set_plan(STUCK, STUCK, STUCK, STUCK);
        run_seq(1'b0, n);
        chk("stuck_cycles", n, 1088);
        chk("stuck_latency", m_lat, 255);
        chk("stuck_timeout", m_to, 1'b1);
        chk("stuck_mismatch", m_mm, 1'b0);

        set_plan(2, 5, 5, 5);
        run_seq(1'b0, n);
        chk("toggle_cycles", n, 85);
        chk("toggle_latency", m_lat, 2);
        chk("toggle_mismatch", m_mm, 1'b1);

        set_plan(255, STUCK, 255, 255);
        run_seq(1'b0, n);
        chk("edge_cycles", n, 1088);
        chk("edge_latency", m_lat, 255);
        chk("edge_timeout", m_to, 1'b1);
        chk("edge_mismatch", m_mm, 1'b0);

        for (int s = 0; s < 3; s++) begin
            base = $urandom_range(0, 40);
            set_plan(base + $urandom_range(0, 8), base + $urandom_range(0, 8),
                     base + $urandom_range(0, 8), base + $urandom_range(0, 8));
            run_seq(1'b0, n);
            chk("rand_cycles", n, end_of(NR - 1));
        end

        set_plan(3, 3, 3, 3);
        repeat (300) @(posedge clk_dut);
        pulse_start();
        n = 0;
        while (!(act && k == end_of(1) + SET + 2) && n < 2000) begin
            @(negedge clk_dut);
            n++;
        end
        chk("reach_run2_measure", n < 2000, 1'b1);
        #2 reset_n = 1'b0;
        @(negedge clk_dut);
        chk("midrst_busy", m_busy, 1'b0);
        chk("midrst_runs", m_rc, 0);
        chk("midrst_latency", m_lat, 0);
        repeat (2) @(negedge clk_dut);
        #2 reset_n = 1'b1;

        set_plan(1, 1, 1, 1);
        run_seq(1'b1, n);
        chk("restart_cycles", n, 72);
        chk("restart_latency", m_lat, 1);
        chk("restart_runs", m_rc, 4);

        repeat (5) @(posedge clk_dut);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/latency_driver.md
Name: latency_driver

Overview:
- Parametrised stimulus driver for the arithmetic testbench, running on the DUT clock.
- Passes LFSR operands to the DUT and measures DUT pipeline latency by injecting marker operands.
- Repeats the measurement N_RUNS times, flags inconsistent results and timeouts, and supplies a configurable-depth delayed operand copy to the monitor.

Parameters:
- WIDTH, 32, operand/result width; any value >= 2 is supported.
- MON_DELAY, 2, register stages on the monitor operand path; legal range 0..15.
- SETTLE, 16, minimum random-drive cycles before each marker injection; >= 1.
- MAX_LAT, 255, latency count at which a run times out; must fit in LAT_W bits.
- LAT_W, 8, width of the latency result.
- N_RUNS, 4, measurement runs per start; range 1..15.
- MARKER_A, 0, operand A value driven during injection.
- MARKER_B, 0, operand B value driven during injection.
- MARKER_OUT, 0, DUT result that identifies the marker.

Ports:
- clk_dut  in  1  DUT clock; only clock in the block.
- reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle pulse that starts a measurement sequence; ignored while o_busy=1.
- i_rand_a  in  WIDTH  LFSR operand A.
- i_rand_b  in  WIDTH  LFSR operand B.
- i_dut_out  in  WIDTH  DUT result.
- o_drive_a  out  WIDTH  operand A to the DUT.
- o_drive_b  out  WIDTH  operand B to the DUT.
- o_drive_delayed_a  out  WIDTH  i_rand_a delayed MON_DELAY cycles, for the monitor.
- o_drive_delayed_b  out  WIDTH  i_rand_b delayed MON_DELAY cycles, for the monitor.
- o_busy  out  1  high from the cycle after an accepted start until DONE.
- o_done  out  1  level; high in DONE.
- o_latency  out  LAT_W  latency measured in the first run.
- o_timeout  out  1  sticky; set if any run reached MAX_LAT.
- o_mismatch  out  1  sticky; set if any run's latency differs from run 0.
- o_run_count  out  4  number of completed runs.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; all counters, o_latency, o_timeout, o_mismatch and o_run_count = 0.
  - o_busy=0, o_done=0.
  - Delay-line registers are not reset.
- Operand outputs:
  - o_drive_a/b = MARKER_A/B combinationally only in INJECT.
  - In every other state (including IDLE), o_drive_a/b = i_rand_a/b.
- Delay line:
  - With MON_DELAY=0, o_drive_delayed_* = i_rand_* combinationally.
  - Otherwise it is a MON_DELAY-stage register chain on i_rand_a and on i_rand_b, independent of state.
- FSM states: IDLE, SETTLE, INJECT, MEASURE, DONE.
- IDLE:
  - i_start=1 -> SETTLE.
  - Clear the settle counter, run counter, o_timeout and o_mismatch.
- SETTLE:
  - The settle counter increments each cycle.
  - Exit to INJECT when count >= SETTLE-1 and i_dut_out != MARKER_OUT in the same cycle.
  - If i_dut_out == MARKER_OUT, stay and keep driving random operands; no upper bound.
- INJECT:
  - Lasts exactly 1 cycle; marker is driven.
  - If i_dut_out == MARKER_OUT in this cycle, the latency is 0 and the run completes.
  - Otherwise -> MEASURE with latency counter=1.
- MEASURE:
  - If i_dut_out == MARKER_OUT, latency = counter and the run completes.
  - Else if counter == MAX_LAT, latency = MAX_LAT, o_timeout <= 1 and the run completes.
  - Else the counter increments.
  - A match and counter==MAX_LAT in the same cycle count as a match, not a timeout.
- Run completion:
  - Run 0 loads o_latency.
  - Runs 1..N_RUNS-1 compare against o_latency and set o_mismatch if they differ; a timed-out run compares as MAX_LAT.
  - o_run_count increments.
  - If o_run_count+1 == N_RUNS -> DONE; else -> SETTLE with the settle counter cleared.
- DONE:
  - o_done=1, o_busy=0; results are held.
  - i_start -> SETTLE with a fresh sequence; results clear as in IDLE.
- Latency definition: the number of rising edges between the end of the INJECT cycle and the cycle in which the marker is sampled.
  - Combinational DUT = 0.
  - One register stage = 1.
- Widths: counters saturate and never wrap; MAX_LAT < 2^LAT_W is checked at elaboration.
- Start pulses while busy are ignored. Reset mid-sequence returns to IDLE immediately and clears results.

Test Plan:
- 3-register-stage pass-through DUT (out=a+b), N_RUNS=4, pulse i_start -> after 4 runs o_done=1, o_latency=3, o_mismatch=0, o_timeout=0, o_run_count=4.
- Combinational DUT (out=a+b) -> o_latency=0 on every run; o_drive_a=0 only in the INJECT cycle.
- DUT stuck at 32'h1 -> each run times out; o_latency=255, o_timeout=1, o_mismatch=0, and o_done is asserted after 4×(SETTLE+1+255) cycles.
- DUT latency toggled 2 -> 5 after run 0 -> o_latency=2, o_mismatch=1.
- Assert reset_n=0 during MEASURE of run 2, then release and start -> outputs are zero during reset; the fresh sequence reports correct results; a second i_start during SETTLE has no effect.
- MON_DELAY=0 and MON_DELAY=2 with i_rand_a=i_rand_b as a ramp -> delayed outputs equal the input ramp 0 and 2 cycles back; a and b are tracked independently.
